// File: rtl/bitwise_iter.sv
// bitwise_iter: registered, handshaked bitwise/shift unit for the execute stage.
// Logic ops finish in one cycle; shifts/rotates iterate STEP bits per cycle.
// Optional feature macro: BITWISE_ROTATE_EN enables ROL/ROR (opcodes 11/12);
// without it those opcodes are treated as unknown logic ops (result 0).
module bitwise_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);
  localparam logic [SHW:0] XLEN_W = (SHW+1)'(XLEN);
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  localparam logic [3:0] OP_XOR  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XNOR = 4'd3;
  localparam logic [3:0] OP_ORN  = 4'd4;
  localparam logic [3:0] OP_ANDN = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] result_q;
  logic [SHW-1:0]  rem;
  logic [3:0]      op_q;
  logic            sign;
  logic            valid_q;
  logic            busy_q;

  logic            is_shift;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] logic_res;
  logic [SHW-1:0]  k;
  logic [SHW:0]    k_comp;
  logic [XLEN-1:0] fill;
  logic [XLEN-1:0] step_res;

  assign shamt    = i_op2[SHW-1:0];
  assign o_ready  = (state == IDLE) && !i_reset;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;
  assign o_result = result_q;

  // Classify the incoming opcode as an iterative shift/rotate.
  always_comb begin
    is_shift = 1'b0;
    case (i_op)
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
`ifdef BITWISE_ROTATE_EN
      OP_ROL, OP_ROR:         is_shift = 1'b1;
`endif
      default:                is_shift = 1'b0;
    endcase
  end

  // Single-cycle logic results; unknown opcodes yield zero.
  always_comb begin
    logic_res = '0;
    case (i_op)
      OP_XOR:  logic_res = i_op1 ^ i_op2;
      OP_OR:   logic_res = i_op1 | i_op2;
      OP_AND:  logic_res = i_op1 & i_op2;
      OP_XNOR: logic_res = ~(i_op1 ^ i_op2);
      OP_ORN:  logic_res = i_op1 | ~i_op2;
      OP_ANDN: logic_res = i_op1 & ~i_op2;
      default: logic_res = '0;
    endcase
  end

  // One iteration: shift acc by min(rem, STEP).
  always_comb begin
    k = ({1'b0, rem} < STEP_W) ? rem : SHW'(STEP);
    k_comp   = XLEN_W - {1'b0, k};
    fill     = ~(ALL_ONES >> k);
    step_res = acc;
    case (op_q)
      OP_SLL:  step_res = acc << k;
      OP_SRL:  step_res = acc >> k;
      OP_SRA:  step_res = (acc >> k) | (sign ? fill : '0);
`ifdef BITWISE_ROTATE_EN
      OP_ROL:  step_res = (acc << k) | (acc >> k_comp);
      OP_ROR:  step_res = (acc >> k) | (acc << k_comp);
`endif
      default: step_res = acc;
    endcase
  end

  // Control FSM with registered result, valid and busy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      acc      <= '0;
      rem      <= '0;
      op_q     <= '0;
      sign     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            busy_q <= 1'b1;
            if (is_shift && (shamt != '0)) begin
              acc   <= i_op1;
              rem   <= shamt;
              op_q  <= i_op;
              sign  <= i_op1[XLEN-1];
              state <= SHIFT;
            end else begin
              result_q <= is_shift ? i_op1 : logic_res;
              valid_q  <= 1'b1;
              state    <= DONE;
            end
          end
        end
        SHIFT: begin
          acc <= step_res;
          rem <= rem - k;
          if (rem == k) begin
            result_q <= step_res;
            valid_q  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_k_comp;
  assign unused_k_comp = ^k_comp;

endmodule

// File: tb/tb_bitwise_iter.sv
// tb_bitwise_iter: directed plus randomized checks of bitwise_iter (XLEN=32, STEP=4)
// against a whole-operation reference model.
module tb_bitwise_iter;

  logic        clk = 1'b0;
  logic        i_reset, i_valid, i_ready;
  logic [3:0]  i_op;
  logic [31:0] i_op1, i_op2;
  logic        o_ready, o_valid, o_busy;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_pass   = 0;

  bitwise_iter #(.XLEN(32), .STEP(4)) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Whole-operation model: full shift in one go, latency from ceil(shamt/4).
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output int lat);
    int unsigned sh;
    logic [31:0] r;
    bit shift_op;
    sh = int'(b[4:0]);
    shift_op = 1'b0;
    r = 32'h0;
    case (op)
      4'd0: r = a ^ b;
      4'd1: r = a | b;
      4'd2: r = a & b;
      4'd3: r = ~(a ^ b);
      4'd4: r = a | ~b;
      4'd5: r = a & ~b;
      4'd8: begin r = a << sh; shift_op = 1'b1; end
      4'd9: begin r = a >> sh; shift_op = 1'b1; end
      4'd10: begin r = $signed(a) >>> sh; shift_op = 1'b1; end
`ifdef BITWISE_ROTATE_EN
      4'd11: begin r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh))); shift_op = 1'b1; end
      4'd12: begin r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh))); shift_op = 1'b1; end
`endif
      default: r = 32'h0;
    endcase
    lat = (shift_op && sh != 0) ? 1 + int'((sh + 3) / 4) : 1;
    return r;
  endfunction

  // Issue one op, check latency/result, optionally stall hold cycles in DONE.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int exp_lat, lat;
    exp = model(op, a, b, exp_lat);
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_op = op; i_op1 = a; i_op2 = b; i_ready = (hold == 0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_op = 4'($urandom); i_op1 = $urandom; i_op2 = $urandom;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, o_result, exp);
    check({tag, "_busy"}, 32'(o_busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      i_valid = 1'b1; i_op = 4'd1; i_op1 = $urandom; i_op2 = $urandom;
      check({tag, "_stall_ready"}, 32'(o_ready), 32'd0);
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, 32'(o_valid), 32'd1);
      check({tag, "_stall_result"}, o_result, exp);
    end
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_hs_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_hs_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_hs_ready"}, 32'(o_ready), 32'd1);
  endtask

  logic [3:0] op_tab [15] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                              4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd15};

  initial begin
    logic [31:0] b;
    logic [3:0] op;
    bit stale;
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_op = '0; i_op1 = '0; i_op2 = '0;

    // Reset state
    @(posedge clk); #1;
    check("rst_ready", 32'(o_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_result", o_result, 32'h0);
    check("rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    i_reset = 1'b0;
    #1;
    check("rst_release_ready", 32'(o_ready), 32'd1);

    // Directed scenarios
    run_op("xor", 4'd0, 32'hF0F0_0000, 32'h0FF0_00FF, 0);
    run_op("sra31", 4'd10, 32'h8000_0000, 32'd31, 0);
    run_op("srl31", 4'd9, 32'h8000_0000, 32'd31, 0);
    run_op("sll0", 4'd8, 32'h1234_5678, 32'hFFFF_FFE0, 0);
    run_op("sll8", 4'd8, 32'h1234_5678, 32'd8, 0);
    run_op("ror4", 4'd12, 32'h0000_0001, 32'd4, 0);
    run_op("rol3", 4'd11, 32'h8000_0001, 32'd3, 0);
    run_op("unk14", 4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("bp_logic", 4'd5, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 3);
    run_op("bp_shift", 4'd10, 32'h9000_0000, 32'd6, 3);

    // Reset in the second SHIFT cycle of SLL by 20
    @(negedge clk);
    i_valid = 1'b1; i_op = 4'd8; i_op1 = 32'hFFFF_FFFF; i_op2 = 32'd20; i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(o_ready), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_result", o_result, 32'h0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    i_reset = 1'b0;
    stale = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (o_valid) stale = 1'b1;
    end
    check("mid_rst_no_stale", 32'(stale), 32'd0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      op = op_tab[$urandom_range(0, 14)];
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b[4:0] = 5'd0;
        1: b[4:0] = 5'd31;
        default: ;
      endcase
      run_op("rand", op, $urandom, b, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
